// File: rtl/sramc_port_arbiter.sv
// Two-requester arbiter for the single-port psum SRAM C: fixed core priority,
// DMA anti-starvation, bounded lock bursts and owner-tagged read return.
module sramc_port_arbiter #(
    parameter int ADR_W      = 11,
    parameter int DATA_W     = 128,
    parameter int N_ELEM     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 15,
    parameter int LOCK_MAX   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic              i_core_lock,
    input  logic [ADR_W-1:0]  i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    input  logic [N_ELEM-1:0] i_core_wmask,
    output logic              o_core_gnt,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic              i_dma_lock,
    input  logic [ADR_W-1:0]  i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    input  logic [N_ELEM-1:0] i_dma_wmask,
    output logic              o_dma_gnt,
    output logic              o_dma_rvalid,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic              o_sram_cs,
    output logic              o_sram_we,
    output logic [ADR_W-1:0]  o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic [N_ELEM-1:0] o_sram_wmask,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_dma_starved
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int LC_W = $clog2(LOCK_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [LC_W-1:0] LOCK_LIM   = LC_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE_LOCK = 2'd1,
        DMA_LOCK  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SC_W-1:0]   starve_cnt;
    logic [LC_W-1:0]   lock_cnt;
    logic [LC_W-1:0]   lock_cnt_nxt;
    logic              starved;
    logic              arb_open;
    logic              core_gnt;
    logic              dma_gnt;
    logic [RD_LAT-1:0] rd_vld_p;
    logic [RD_LAT-1:0] rd_dma_p;

    // Arbitration: a lock holder keeps the port until it drops req, ends the
    // burst, or exhausts LOCK_MAX; otherwise the port is re-arbitrated at once.
    always_comb begin
        starved      = (starve_cnt == STARVE_LIM);
        core_gnt     = 1'b0;
        dma_gnt      = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            CORE_LOCK: arb_open = !i_core_req || (lock_cnt == LOCK_LIM);
            DMA_LOCK:  arb_open = !i_dma_req  || (lock_cnt == LOCK_LIM);
            default:   arb_open = 1'b1;
        endcase

        if (arb_open) begin
            if (starved && i_dma_req) begin
                dma_gnt = 1'b1;
            end else if (i_core_req) begin
                core_gnt = 1'b1;
            end else if (i_dma_req) begin
                dma_gnt = 1'b1;
            end
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
            if (core_gnt && i_core_lock) begin
                state_nxt    = CORE_LOCK;
                lock_cnt_nxt = LC_W'(1);
            end else if (dma_gnt && i_dma_lock) begin
                state_nxt    = DMA_LOCK;
                lock_cnt_nxt = LC_W'(1);
            end
        end else if (state == CORE_LOCK) begin
            core_gnt     = 1'b1;
            lock_cnt_nxt = lock_cnt + 1'b1;
            if (!i_core_lock) begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        end else begin
            dma_gnt      = 1'b1;
            lock_cnt_nxt = lock_cnt + 1'b1;
            if (!i_dma_lock) begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (i_dma_req && !dma_gnt) begin
                starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Read-return pipe: stage 0 captures {read, owner} on the grant cycle,
    // the last stage lines up with i_sram_rdata.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_vld_p <= '0;
            rd_dma_p <= '0;
        end else begin
            rd_vld_p[0] <= (core_gnt && !i_core_we) || (dma_gnt && !i_dma_we);
            rd_dma_p[0] <= dma_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
                rd_dma_p[i] <= rd_dma_p[i-1];
            end
        end
    end

    always_comb begin
        o_sram_we    = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_sram_wmask = '0;
        if (core_gnt) begin
            o_sram_we    = i_core_we;
            o_sram_addr  = i_core_addr;
            o_sram_wdata = i_core_wdata;
            o_sram_wmask = i_core_wmask;
        end else if (dma_gnt) begin
            o_sram_we    = i_dma_we;
            o_sram_addr  = i_dma_addr;
            o_sram_wdata = i_dma_wdata;
            o_sram_wmask = i_dma_wmask;
        end
    end

    assign o_sram_cs     = core_gnt | dma_gnt;
    assign o_core_gnt    = core_gnt;
    assign o_dma_gnt     = dma_gnt;
    assign o_dma_starved = starved;
    assign o_core_rvalid = rd_vld_p[RD_LAT-1] & ~rd_dma_p[RD_LAT-1];
    assign o_dma_rvalid  = rd_vld_p[RD_LAT-1] &  rd_dma_p[RD_LAT-1];
    assign o_core_rdata  = i_sram_rdata;
    assign o_dma_rdata   = i_sram_rdata;

endmodule

// File: tb/tb_sramc_port_arbiter.sv
// Directed bench for sramc_port_arbiter: inputs change 1 time unit after the
// rising edge, outputs are checked on the falling edge.
module tb_sramc_port_arbiter;

    localparam int ADR_W  = 11;
    localparam int DATA_W = 128;
    localparam int N_ELEM = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we, core_lock;
    logic [ADR_W-1:0]  core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [N_ELEM-1:0] core_wmask;
    logic              core_gnt, core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              dma_req, dma_we, dma_lock;
    logic [ADR_W-1:0]  dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [N_ELEM-1:0] dma_wmask;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              sram_cs, sram_we;
    logic [ADR_W-1:0]  sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [N_ELEM-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_rdata;
    logic              dma_starved;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sramc_port_arbiter #(
        .ADR_W(ADR_W), .DATA_W(DATA_W), .N_ELEM(N_ELEM),
        .RD_LAT(1), .STARVE_MAX(15), .LOCK_MAX(16)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_lock(core_lock),
        .i_core_addr(core_addr), .i_core_wdata(core_wdata), .i_core_wmask(core_wmask),
        .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_lock(dma_lock),
        .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata), .i_dma_wmask(dma_wmask),
        .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
        .o_sram_cs(sram_cs), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata), .o_sram_wmask(sram_wmask),
        .i_sram_rdata(sram_rdata), .o_dma_starved(dma_starved)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b, required %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        core_req = 1'b0; core_we = 1'b0; core_lock = 1'b0;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_lock  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        core_addr = '0; core_wdata = '0; core_wmask = '0;
        dma_addr  = '0; dma_wdata  = '0; dma_wmask  = '0;
        sram_rdata = '0;

        // reset state
        @(negedge clk);
        chk1("rst_core_rvalid", core_rvalid, 1'b0);
        chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
        chk1("rst_starved", dma_starved, 1'b0);
        chk1("rst_cs", sram_cs, 1'b0);
        chkw("rst_addr", 128'(sram_addr), 128'h0);
        tick();
        rst = 1'b0;
        tick();

        // single core read at 0x010
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'h010;
        @(negedge clk);
        chk1("a_core_gnt", core_gnt, 1'b1);
        chk1("a_dma_gnt", dma_gnt, 1'b0);
        chk1("a_cs", sram_cs, 1'b1);
        chk1("a_we", sram_we, 1'b0);
        chkw("a_addr", 128'(sram_addr), 128'h010);
        tick();
        core_req = 1'b0;
        sram_rdata = 128'hA5A5_0001_0002_0003_0004_0005_0006_0007;
        @(negedge clk);
        chk1("a_core_rvalid", core_rvalid, 1'b1);
        chk1("a_dma_rvalid", dma_rvalid, 1'b0);
        chkw("a_core_rdata", core_rdata, 128'hA5A5_0001_0002_0003_0004_0005_0006_0007);
        chk1("a_cs_idle", sram_cs, 1'b0);
        tick();
        @(negedge clk);
        chk1("a_core_rvalid_once", core_rvalid, 1'b0);
        tick();

        // both requesting continuously without lock
        core_req = 1'b1; core_we = 1'b1; core_addr = 11'h020;
        dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 11'h030;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk1($sformatf("b_core_gnt_c%0d", k), core_gnt, k != 16);
            chk1($sformatf("b_dma_gnt_c%0d", k), dma_gnt, k == 16);
            chk1($sformatf("b_starved_c%0d", k), dma_starved, k == 16);
            tick();
        end
        quiet();
        tick();

        // core lock burst of 20 writes against a requesting DMA
        core_req = 1'b1; core_we = 1'b1; core_lock = 1'b1;
        dma_req  = 1'b1; dma_we  = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            chk1($sformatf("c_core_gnt_c%0d", k), core_gnt, k != 17);
            chk1($sformatf("c_dma_gnt_c%0d", k), dma_gnt, k == 17);
            chk1($sformatf("c_starved_c%0d", k), dma_starved, k == 16 || k == 17);
            chk1($sformatf("c_we_c%0d", k), sram_we, 1'b1);
            tick();
        end
        core_req = 1'b0; core_lock = 1'b0;
        @(negedge clk);
        chk1("c_dma_after_burst", dma_gnt, 1'b1);
        tick();
        quiet();
        tick();

        // alternating owners: DMA read, core read, DMA masked write
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h7FF;
        @(negedge clk);
        chk1("d_dma_gnt1", dma_gnt, 1'b1);
        chkw("d_addr1", 128'(sram_addr), 128'h7FF);
        tick();
        dma_req = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'h000;
        sram_rdata = 128'h1111;
        @(negedge clk);
        chk1("d_dma_rvalid", dma_rvalid, 1'b1);
        chk1("d_core_rvalid_n", core_rvalid, 1'b0);
        chkw("d_dma_rdata", dma_rdata, 128'h1111);
        chk1("d_core_gnt2", core_gnt, 1'b1);
        chkw("d_addr2", 128'(sram_addr), 128'h000);
        tick();
        core_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 11'h100;
        dma_wmask = 8'h0F; dma_wdata = 128'hBEEF;
        sram_rdata = 128'h2222;
        @(negedge clk);
        chk1("d_core_rvalid", core_rvalid, 1'b1);
        chk1("d_dma_rvalid_n", dma_rvalid, 1'b0);
        chkw("d_core_rdata", core_rdata, 128'h2222);
        chk1("d_dma_gnt3", dma_gnt, 1'b1);
        chk1("d_we3", sram_we, 1'b1);
        chkw("d_wmask3", 128'(sram_wmask), 128'h0F);
        chkw("d_addr3", 128'(sram_addr), 128'h100);
        chkw("d_wdata3", sram_wdata, 128'hBEEF);
        tick();
        quiet();
        @(negedge clk);
        chk1("d_no_write_rvalid_c", core_rvalid, 1'b0);
        chk1("d_no_write_rvalid_d", dma_rvalid, 1'b0);
        tick();

        // starved DMA read, then asynchronous reset before its return
        core_req = 1'b1; core_we = 1'b1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h055;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk1($sformatf("e_core_gnt_c%0d", k), core_gnt, 1'b1);
            tick();
        end
        @(negedge clk);
        chk1("e_dma_gnt", dma_gnt, 1'b1);
        chk1("e_starved_pre", dma_starved, 1'b1);
        chk1("e_sram_we", sram_we, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk1("e_starved_rst", dma_starved, 1'b0);
        chk1("e_dma_rvalid_rst", dma_rvalid, 1'b0);
        chk1("e_core_rvalid_rst", core_rvalid, 1'b0);
        tick();
        chk1("e_dma_rvalid_dropped", dma_rvalid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("e_core_gnt_rel", core_gnt, 1'b1);
        chk1("e_dma_gnt_rel", dma_gnt, 1'b0);
        chk1("e_starved_rel", dma_starved, 1'b0);
        chk1("e_dma_rvalid_rel", dma_rvalid, 1'b0);
        tick();
        quiet();
        tick();

        // core lock released on its 3rd grant, then a DMA lock holding off core
        core_req = 1'b1; core_we = 1'b1; core_lock = 1'b1;
        dma_req = 1'b1; dma_we = 1'b1;
        @(negedge clk);
        chk1("f_core_gnt1", core_gnt, 1'b1);
        tick();
        @(negedge clk);
        chk1("f_core_gnt2", core_gnt, 1'b1);
        tick();
        core_lock = 1'b0;
        @(negedge clk);
        chk1("f_core_gnt3", core_gnt, 1'b1);
        chk1("f_dma_gnt3", dma_gnt, 1'b0);
        tick();
        core_req = 1'b0; dma_lock = 1'b1;
        @(negedge clk);
        chk1("f_core_gnt4", core_gnt, 1'b0);
        chk1("f_dma_gnt4", dma_gnt, 1'b1);
        tick();
        core_req = 1'b1;
        @(negedge clk);
        chk1("f_core_denied5", core_gnt, 1'b0);
        chk1("f_dma_gnt5", dma_gnt, 1'b1);
        tick();
        dma_lock = 1'b0;
        @(negedge clk);
        chk1("f_core_denied6", core_gnt, 1'b0);
        chk1("f_dma_gnt6", dma_gnt, 1'b1);
        tick();
        @(negedge clk);
        chk1("f_core_gnt7", core_gnt, 1'b1);
        chk1("f_dma_gnt7", dma_gnt, 1'b0);
        tick();
        quiet();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sramc_port_arbiter.md
Name: sramc_port_arbiter

Overview:
- Shares the single-port SRAM C (psum memory) between two requesters: the core-side psum manager (core) and the DMA data mover (dma).
- Arbitrates per cycle with fixed core priority, DMA anti-starvation and bounded burst locks.
- Tags each read and routes its returned data to the requester that issued it.
- Sits between the SRAM C macro/RF wrapper and its two clients in the accelerator core clock domain.

Parameters:
- ADR_W, 11, SRAM C address width (2048 words).
- DATA_W, 128, SRAM C word width.
- N_ELEM, 8, write-mask lanes (DATA_W/16, one lane per 16-bit psum).
- RD_LAT, 1, SRAM read latency in cycles (1..3).
- STARVE_MAX, 15, consecutive denied DMA request cycles before DMA is forced.
- LOCK_MAX, 16, maximum consecutive grants under one lock before forced release.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  asynchronous active-high reset
- i_core_req  in  1  core access request
- i_core_we  in  1  core write enable (1 = write)
- i_core_lock  in  1  core requests that its grant be kept next cycle
- i_core_addr  in  ADR_W  core address
- i_core_wdata  in  DATA_W  core write data
- i_core_wmask  in  N_ELEM  core lane write mask
- o_core_gnt  out  1  core access accepted this cycle
- o_core_rvalid  out  1  core read data valid
- o_core_rdata  out  DATA_W  core read data
- i_dma_req, i_dma_we, i_dma_lock, i_dma_addr, i_dma_wdata, i_dma_wmask  in  same widths as core  DMA request fields
- o_dma_gnt, o_dma_rvalid  out  1  DMA grant and read valid
- o_dma_rdata  out  DATA_W  DMA read data
- o_sram_cs  out  1  SRAM chip select
- o_sram_we  out  1  SRAM write enable
- o_sram_addr  out  ADR_W  SRAM address
- o_sram_wdata  out  DATA_W  SRAM write data
- o_sram_wmask  out  N_ELEM  SRAM lane mask
- i_sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after a read cs
- o_dma_starved  out  1  DMA forced-priority flag (status)

Behaviour:
- Handshake: a transaction is accepted in any cycle where req and gnt are both 1. Gnt is combinational from req and state; gnt is never 1 without req. A requester must hold its fields stable until granted.
- At most one gnt per cycle. o_sram_cs = o_core_gnt | o_dma_gnt. SRAM fields are muxed combinationally from the granted requester; when neither is granted they are forced to 0.
- State machine, 2-bit register, reset value IDLE:
  - IDLE: if the starve counter equals STARVE_MAX and i_dma_req, grant DMA; else if i_core_req, grant core; else if i_dma_req, grant DMA. A grant with lock=1 moves to that requester's LOCK state (CORE_LOCK or DMA_LOCK) and loads lock_cnt=1.
  - CORE_LOCK / DMA_LOCK: the owner is granted whenever it requests; the other requester is denied. Exit to IDLE, with normal arbitration in that same cycle, when any of these holds: owner req=0, owner lock=0 on a granted cycle (that grant is the last of the burst), or lock_cnt reaches LOCK_MAX. lock_cnt increments per owner grant.
- Starve counter, width clog2(STARVE_MAX+1), reset 0: increments (saturating) on each cycle with i_dma_req & !o_dma_gnt; clears on o_dma_gnt or !i_dma_req. o_dma_starved = (counter == STARVE_MAX). A forced DMA grant never preempts an active CORE_LOCK; it applies at the next IDLE arbitration.
- Read return: an RD_LAT-deep shift pipe of {valid, owner} is loaded with {gnt & !we, owner} each cycle. At the pipe output, the matching o_*_rvalid is asserted for 1 cycle. Both o_*_rdata outputs carry i_sram_rdata unconditionally; consumers qualify with rvalid. Back-to-back reads from alternating owners each return correctly in order.
- Writes produce no response. A write followed by a read to the same address returns the new data, since the SRAM serialises them.
- Reset (asynchronous, any time): state IDLE, counters 0, read pipe cleared, so o_core_rvalid = o_dma_rvalid = o_dma_starved = 0. In-flight reads are dropped without rvalid.
- Reset values of all other outputs follow from inputs: gnt and SRAM controls are 0 unless a request is present after reset release.

Test Plan:
- Idle, then one core read at addr 0x010 -> o_core_gnt=1 in the same cycle, o_sram_cs=1/we=0/addr=0x010, o_core_rvalid=1 exactly RD_LAT=1 cycle later, o_dma_rvalid=0.
- Core and DMA request continuously, no lock -> core granted for 15 cycles, o_dma_starved=1 in cycle 16, DMA granted in cycle 16, counter returns to 0, core granted in cycle 17.
- Core lock burst of 20 writes with DMA requesting -> core granted 16 consecutive cycles, forced release, DMA (starved) granted in cycle 17, core resumes afterwards.
- Alternating grants: DMA read 0x7FF, core read 0x000, DMA write 0x100 mask 0x0F -> rvalid pulses go DMA then core in consecutive cycles, no rvalid for the write, o_sram_wmask=0x0F on the write cycle.
- DMA read granted, then i_rst asserted asynchronously before the return cycle -> no rvalid, all status 0 immediately, normal arbitration on first cycle after release.
- Lock released by deasserting lock on the 3rd grant -> exactly 3 owner grants, then IDLE arbitration in the next cycle.
